// File: rtl/wb_write_arbiter_if.sv
// Writeback request/commit bundle between the ALU/load producers,
// the write arbiter and the register-file write port.
interface wb_write_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
);
  logic                      alu_valid;
  logic [REG_BITS-1:0]       alu_reg;
  logic [WIDTH-1:0]          alu_data;
  logic                      alu_ready;
  logic                      mem_valid;
  logic [REG_BITS-1:0]       mem_reg;
  logic [WIDTH-1:0]          mem_data;
  logic                      mem_ready;
  logic                      wb_stall;
  logic                      reg_write;
  logic [REG_BITS-1:0]       write_reg;
  logic [WIDTH-1:0]          write_data;
  logic [(2**REG_BITS)-1:0]  pending;
  logic                      full;
  logic                      drop_pulse;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output wb_stall,
    input  alu_ready, mem_ready,
    input  reg_write, write_reg, write_data,
    input  pending, full, drop_pulse
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  wb_stall,
    output alu_ready, mem_ready,
    output reg_write, write_reg, write_data,
    output pending, full, drop_pulse
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges ALU and load writebacks into one in-order queue that
// drains into the register-file write port, one entry per cycle.
module wb_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input logic           clk,
  input logic           rst,
  wb_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2 ** REG_BITS;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [WIDTH-1:0]    data;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          rr_ptr;
  logic          drop_q;

  logic          alu_drop;
  logic          mem_drop;
  logic          alu_req;
  logic          mem_req;
  logic          alu_ok;
  logic          mem_ok;
  logic          contend;
  logic          push_alu;
  logic          push_mem;
  logic          pop;
  logic          head_valid;
  logic [NR-1:0] pend;

  function automatic logic is_drop(
    input logic [REG_BITS-1:0] r
  );
    return (r == '0) || (r == REG_BITS'(30));
  endfunction

  assign free = CW'(DEPTH) - count;

  always_comb begin
    alu_drop = is_drop(bus.alu_reg);
    mem_drop = is_drop(bus.mem_reg);
    alu_req  = bus.alu_valid && !alu_drop;
    mem_req  = bus.mem_valid && !mem_drop;
    contend  = alu_req && mem_req
             && (free == CW'(1));
    alu_ok   = 1'b0;
    mem_ok   = 1'b0;
    unique case (1'b1)
      (free >= CW'(2)): begin
        alu_ok = 1'b1;
        mem_ok = 1'b1;
      end
      (free == CW'(1)): begin
        // Single slot left: rr_ptr breaks the tie.
        alu_ok = !(mem_req && rr_ptr);
        mem_ok = !(alu_req && !rr_ptr);
      end
      (free == '0): begin
        alu_ok = 1'b0;
        mem_ok = 1'b0;
      end
      default: begin
        alu_ok = 1'b0;
        mem_ok = 1'b0;
      end
    endcase
    push_alu = !rst && alu_req && alu_ok;
    push_mem = !rst && mem_req && mem_ok;
  end

  assign bus.alu_ready = !rst && (alu_drop || alu_ok);
  assign bus.mem_ready = !rst && (mem_drop || mem_ok);

  assign head_valid     = (count != '0);
  assign pop            = head_valid && !bus.wb_stall;
  assign bus.reg_write  = head_valid;
  assign bus.write_reg  = head_valid ? q[rd_ptr].rd   : '0;
  assign bus.write_data = head_valid ? q[rd_ptr].data : '0;
  assign bus.full       = (count == CW'(DEPTH));
  assign bus.drop_pulse = drop_q;
  assign bus.pending    = pend;

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - rd_ptr} < count) begin
        pend[q[i].rd] = 1'b1;
      end
    end
    pend[0]  = 1'b0;
    pend[30] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_alu) begin
      q[wr_ptr] <= '{bus.alu_reg, bus.alu_data};
    end
    if (push_mem) begin
      q[wr_ptr + PW'(push_alu)] <=
        '{bus.mem_reg, bus.mem_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr_ptr <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      wr_ptr <= wr_ptr + PW'(push_alu)
              + PW'(push_mem);
      count  <= count + CW'(push_alu)
              + CW'(push_mem) - CW'(pop);
      if (contend) begin
        rr_ptr <= !rr_ptr;
      end
      drop_q <= (bus.alu_valid && alu_drop)
             || (bus.mem_valid && mem_drop);
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized scoreboard bench for the writeback arbiter: a queue-level
// model predicts readies/status, a monitor checks commit order.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int RB    = 5;

  typedef struct {
    logic [RB-1:0]    r;
    logic [WIDTH-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_write_arbiter_if #(
    .WIDTH(WIDTH), .REG_BITS(RB)
  ) bus ();

  wb_write_arbiter #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .REG_BITS(RB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t             mq[$];
  ent_t             sb_q[$];
  logic [WIDTH-1:0] rf [32];
  int               checks = 0;
  int               errors = 0;
  bit               mrr = 1'b0;
  bit               exp_drop = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit droppable(input logic [RB-1:0] r);
    return (r == 5'd0) || (r == 5'd30);
  endfunction

  // Reference model: queue contents, occupancy and the tie-break
  // bit, advanced once per cycle from the arbitration rules.
  always @(negedge clk) begin
    int          free;
    bit          ar, mr, ea, em;
    logic [31:0] pm;
    free = DEPTH - mq.size();
    ar = bus.alu_valid && !droppable(bus.alu_reg);
    mr = bus.mem_valid && !droppable(bus.mem_reg);
    if (rst) begin
      ea = 1'b0;
      em = 1'b0;
    end else begin
      ea = droppable(bus.alu_reg) || free >= 2
         || (free == 1 && !(mr && mrr));
      em = droppable(bus.mem_reg) || free >= 2
         || (free == 1 && !(ar && !mrr));
    end
    if (bus.alu_valid)
      chk("alu_ready", 32'(bus.alu_ready), 32'(ea));
    if (bus.mem_valid)
      chk("mem_ready", 32'(bus.mem_ready), 32'(em));
    chk("reg_write", 32'(bus.reg_write), 32'(mq.size() != 0));
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    pm = '0;
    foreach (mq[i]) pm[mq[i].r] = 1'b1;
    chk("pending", bus.pending, pm);
    chk("drop_pulse", 32'(bus.drop_pulse), 32'(exp_drop));
    if (mq.size() == 0) begin
      chk("empty_reg", 32'(bus.write_reg), 32'd0);
      chk("empty_data", bus.write_data, 32'd0);
    end
    if (rst) begin
      mq.delete();
      sb_q.delete();
      mrr = 1'b0;
      exp_drop = 1'b0;
    end else begin
      if (mq.size() != 0 && !bus.wb_stall)
        void'(mq.pop_front());
      if (ar && ea) begin
        mq.push_back('{bus.alu_reg, bus.alu_data});
        sb_q.push_back('{bus.alu_reg, bus.alu_data});
      end
      if (mr && em) begin
        mq.push_back('{bus.mem_reg, bus.mem_data});
        sb_q.push_back('{bus.mem_reg, bus.mem_data});
      end
      if (ar && mr && free == 1) mrr = !mrr;
      exp_drop = (bus.alu_valid && droppable(bus.alu_reg))
              || (bus.mem_valid && droppable(bus.mem_reg));
    end
  end

  // Commit monitor: every write the register file takes must be
  // the oldest accepted, not-yet-committed request.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && bus.reg_write && !bus.wb_stall) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected: got r%0d=%h expected none",
                 bus.write_reg, bus.write_data);
      end else begin
        e = sb_q.pop_front();
        chk("commit_reg", 32'(bus.write_reg), 32'(e.r));
        chk("commit_data", bus.write_data, e.d);
      end
      rf[bus.write_reg] = bus.write_data;
    end
  end

  task automatic drive(input bit av,
                       input logic [RB-1:0] ar,
                       input logic [WIDTH-1:0] ad,
                       input bit mv,
                       input logic [RB-1:0] mr,
                       input logic [WIDTH-1:0] md,
                       input bit st);
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    bus.wb_stall  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++)
      drive(0, '0, '0, 0, '0, '0, st);
  endtask

  function automatic logic [RB-1:0] rnd_reg();
    if ($urandom_range(0, 7) == 0)
      return $urandom_range(0, 1) ? 5'd0 : 5'd30;
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int guard;
    foreach (rf[i]) rf[i] = '0;
    rst = 1'b1;
    idle(2, 0);
    rst = 1'b0;
    idle(1, 0);

    // single write
    drive(1, 5'd5, 32'hAA, 0, '0, '0, 0);
    chk("single_rw", 32'(bus.reg_write), 32'd1);
    chk("single_pend", bus.pending, 32'h20);
    idle(3, 0);
    chk("single_rf", rf[5], 32'hAA);

    // dual push, same destination
    drive(1, 5'd3, 32'd7, 1, 5'd3, 32'd9, 0);
    idle(4, 0);
    chk("dual_rf", rf[3], 32'd9);

    // contention and fairness
    drive(1, 5'd10, 32'h10, 1, 5'd11, 32'h11, 1);
    drive(1, 5'd12, 32'h12, 0, '0, '0, 1);
    drive(1, 5'd1, 32'h101, 1, 5'd2, 32'h201, 1);
    idle(1, 0);
    drive(1, 5'd1, 32'h102, 1, 5'd2, 32'h202, 1);
    chk("full_at_4", 32'(bus.full), 32'd1);
    drive(1, 5'd1, 32'h103, 1, 5'd2, 32'h203, 1);

    // droppable requests while full
    drive(1, 5'd30, 32'h66, 1, 5'd0, 32'h55, 1);
    chk("drop_pulse_dir", 32'(bus.drop_pulse), 32'd1);
    chk("drop_full", 32'(bus.full), 32'd1);
    idle(6, 0);
    chk("fair_rf2", rf[2], 32'h202);

    // stall hold
    drive(1, 5'd4, 32'd1, 1, 5'd6, 32'd2, 1);
    idle(3, 1);
    chk("stall_reg", 32'(bus.write_reg), 32'd4);
    chk("stall_pend", bus.pending, 32'h50);
    idle(3, 0);
    chk("stall_rf6", rf[6], 32'd2);

    // mid-operation reset
    drive(1, 5'd8, 32'h8, 1, 5'd9, 32'h9, 1);
    drive(1, 5'd10, 32'hA0, 0, '0, '0, 1);
    rst = 1'b1;
    drive(1, 5'd11, 32'hB0, 0, '0, '0, 1);
    rst = 1'b0;
    chk("rst_rw", 32'(bus.reg_write), 32'd0);
    chk("rst_pend", bus.pending, 32'd0);
    drive(1, 5'd7, 32'h1234, 0, '0, '0, 0);
    idle(3, 0);
    chk("rst_rf7", rf[7], 32'h1234);
    chk("rst_rf8", rf[8], 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1), rnd_reg(), $urandom(),
            $urandom_range(0, 1), rnd_reg(), $urandom(),
            $urandom_range(0, 2) == 0);
    end
    rst = 1'b0;

    guard = 0;
    while (bus.reg_write && guard < 20) begin
      idle(1, 0);
      guard++;
    end
    idle(1, 0);
    chk("drained", 32'(bus.reg_write), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
